mips_pipe_control: RTL
======================

// Module: mips_pipe_control
// PURPOSE
//  5-stage pipelined successor of the single-cycle MIPS control decoder. Decodes ID-stage opcode,
//  carries control bundle through ID/EX, EX/MEM, MEM/WB registers, detects load-use hazards (stall),
//  resolves branches in EX and jumps in ID (flush). Sits between IF/ID register and datapath stages.
// PARAMETERS
//  OP_W       6   opcode width
//  ALUOP_W    6   ALUOp width (GreenCard opcode passthrough; 0 for R-type)
//  REG_W      5   register-address width
//  CNT_W      16  perf-counter width (used only with CTRL_PERF_CNT_EN)
// PORTS
//  clk            in   1        rising-edge clock
//  reset          in   1        asynchronous, active-high reset
//  OP             in   OP_W     ID-stage opcode
//  id_rs/id_rt/id_rd in REG_W   ID-stage register fields
//  ex_zero        in   1        ALU zero flag of instruction in EX
//  stall          out  1        hold PC and IF/ID (load-use)
//  ifid_flush     out  1        zero IF/ID next edge (taken branch or jump)
//  branch_taken   out  1        EX branch resolved taken; PC <- branch target
//  jump           out  1        ID jump; PC <- jump target
//  ex_RegDst/ex_ALUSrc out 1; ex_ALUOp out ALUOP_W; ex_dest out REG_W
//  mem_MemRead/mem_MemWrite out 1; mem_dest out REG_W
//  wb_MemtoReg/wb_RegWrite  out 1; wb_dest  out REG_W
//  stall_cnt/flush_cnt out CNT_W  (only with CTRL_PERF_CNT_EN)
// BEHAVIOUR
//  - Decode (combinational): R 00, J 02, BEQ 04, BNE 05, ADDI 08, ORI 0d, LUI 0f, LW 23, SW 2b.
//    Unknown opcode -> all-zero bundle (bubble). ALUOp = OP for I/branch types, 0 for R/J.
//  - ex_dest = RegDst ? rd : rt, latched into ID/EX; propagates unchanged EX->MEM->WB.
//  - Latency: control for instr in ID appears on ex_* 1 cycle later, mem_* 2, wb_* 3.
//  - Load-use: stall=1 when ID/EX.MemRead && ID/EX.rt!=0 && (rt==id_rs || (rt==id_rt && ID uses rt:
//    R, SW, BEQ, BNE)). On stall: ID/EX loads bubble; EX/MEM, MEM/WB advance. Exactly 1 cycle.
//  - Branch: branch_taken = (ex_BEQ & ex_zero) | (ex_BNE & ~ex_zero), combinational from ID/EX;
//    asserts ifid_flush and ID/EX loads bubble next edge (2-instruction penalty).
//  - Jump: jump=1 when ID op==J and not branch_taken; asserts ifid_flush (1 bubble); no EX effect.
//  - Priority: reset > branch_taken > stall > normal. branch_taken suppresses stall and jump
//    (squashed instr). stall and jump never coexist (J reads no regs).
//  - Bubble = all-zero bundle, dest=0; never writes memory or registers.
//  - Reset (async, any time, incl. mid-stall/flush): all pipeline regs and outputs 0; first edge
//    after release decodes OP normally.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined: stall_cnt +1 per stall cycle, flush_cnt +1 per ifid_flush cycle;
//    both saturate at all-ones, reset to 0. Undefined: ports and counters absent, no other change.
// STRUCTURE
//  - Package mips_ctrl_pkg: opcode localparams, ctrl_bundle_t struct (RegDst, ALUSrc, MemtoReg,
//    RegWrite, MemRead, MemWrite, BranchNE, BranchEQ, ALUOp), CTRL_BUBBLE constant.
//  - Sub-module mips_ctrl_decode: pure combinational OP -> ctrl_bundle_t; hazard/flush logic and
//    stage registers stay in top.
// TESTING
//  1 reset held, random OP -> all outputs 0; release, OP=08 -> next edge ex_ALUSrc=1, ex_ALUOp=08.
//  2 LW rt=5 then R-type rs=5 -> stall=1 one cycle, ex_* zero that cycle, then R-type in EX.
//  3 LW rt=0 then R-type rs=0 -> stall=0; LW rt=5 then ADDI rt=5,rs=3 -> stall=0.
//  4 BEQ in EX, ex_zero=1 -> branch_taken=1, ifid_flush=1, next ex_* zero; ex_zero=0 -> no flush.
//  5 J in ID with BNE taken in EX -> jump=0, branch_taken=1; J alone -> jump=1, one bubble.
//  6 CTRL_PERF_CNT_EN, CNT_W=2: 5 stalls -> stall_cnt=3 (saturated); reset mid-count -> 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the pipelined MIPS control path: opcodes,
// the per-instruction control bundle, and the bubble constant.
package mips_ctrl_pkg;

  localparam int unsigned CTRL_ALUOP_W = 6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef struct packed {
    logic                    RegDst;
    logic                    ALUSrc;
    logic                    MemtoReg;
    logic                    RegWrite;
    logic                    MemRead;
    logic                    MemWrite;
    logic                    BranchNE;
    logic                    BranchEQ;
    logic [CTRL_ALUOP_W-1:0] ALUOp;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  // Instructions whose rt field is a source operand (load-use candidates on rt).
  function automatic logic usesRt(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_SW, OP_BEQ, OP_BNE};
  endfunction

endpackage

// File: rtl/mips_pipe_control_if.sv
// Control-path bus between the pipeline controller (master) and the datapath (slave).
// Perf counter signals exist only when CTRL_PERF_CNT_EN is defined.
interface mips_pipe_control_if #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 6,
  parameter int unsigned REG_W   = 5
`ifdef CTRL_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
);
  logic [OP_W-1:0]    OP;
  logic [REG_W-1:0]   id_rs;
  logic [REG_W-1:0]   id_rt;
  logic [REG_W-1:0]   id_rd;
  logic               ex_zero;
  logic               stall;
  logic               ifid_flush;
  logic               branch_taken;
  logic               jump;
  logic               ex_RegDst;
  logic               ex_ALUSrc;
  logic [ALUOP_W-1:0] ex_ALUOp;
  logic [REG_W-1:0]   ex_dest;
  logic               mem_MemRead;
  logic               mem_MemWrite;
  logic [REG_W-1:0]   mem_dest;
  logic               wb_MemtoReg;
  logic               wb_RegWrite;
  logic [REG_W-1:0]   wb_dest;
`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;
`endif

  modport master (
    input  OP, id_rs, id_rt, id_rd, ex_zero,
    output stall, ifid_flush, branch_taken, jump,
    output ex_RegDst, ex_ALUSrc, ex_ALUOp, ex_dest,
    output mem_MemRead, mem_MemWrite, mem_dest,
    output wb_MemtoReg, wb_RegWrite, wb_dest
`ifdef CTRL_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );

  modport slave (
    output OP, id_rs, id_rt, id_rd, ex_zero,
    input  stall, ifid_flush, branch_taken, jump,
    input  ex_RegDst, ex_ALUSrc, ex_ALUOp, ex_dest,
    input  mem_MemRead, mem_MemWrite, mem_dest,
    input  wb_MemtoReg, wb_RegWrite, wb_dest
`ifdef CTRL_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode decoder: ID-stage opcode to control bundle.
// Unknown opcodes and J produce an all-zero bundle.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   op,
  output ctrl_bundle_t ctrl
);

  always_comb begin
    ctrl = CTRL_BUBBLE;
    case (op)
      OP_RTYPE: begin
        ctrl.RegDst   = 1'b1;
        ctrl.RegWrite = 1'b1;
      end
      OP_BEQ: begin
        ctrl.BranchEQ = 1'b1;
        ctrl.ALUOp    = op;
      end
      OP_BNE: begin
        ctrl.BranchNE = 1'b1;
        ctrl.ALUOp    = op;
      end
      OP_ADDI, OP_ORI, OP_LUI: begin
        ctrl.ALUSrc   = 1'b1;
        ctrl.RegWrite = 1'b1;
        ctrl.ALUOp    = op;
      end
      OP_LW: begin
        ctrl.ALUSrc   = 1'b1;
        ctrl.MemtoReg = 1'b1;
        ctrl.RegWrite = 1'b1;
        ctrl.MemRead  = 1'b1;
        ctrl.ALUOp    = op;
      end
      OP_SW: begin
        ctrl.ALUSrc   = 1'b1;
        ctrl.MemWrite = 1'b1;
        ctrl.ALUOp    = op;
      end
      default: ctrl = CTRL_BUBBLE;
    endcase
  end

endmodule

// File: rtl/mips_pipe_control.sv
// 5-stage MIPS pipeline controller: decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall, branch (EX) / jump (ID) flush. Optional perf counters: CTRL_PERF_CNT_EN.
module mips_pipe_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 6,
  parameter int unsigned REG_W   = 5
`ifdef CTRL_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_pipe_control_if.master  bus
);

  logic [OP_W-1:0]  idOpFull;
  logic [5:0]       idOp;
  ctrl_bundle_t     idCtrl;
  logic [REG_W-1:0] idDest;

  ctrl_bundle_t     exCtrl;
  logic [REG_W-1:0] exDest;
  logic [REG_W-1:0] exRt;
  logic             memRead, memWrite, memMemtoReg, memRegWrite;
  logic [REG_W-1:0] memDest;
  logic             wbMemtoReg, wbRegWrite;
  logic [REG_W-1:0] wbDest;

  logic branchTaken, loadUse, stallInt, jumpInt, insertBubble;

  assign idOpFull = bus.OP;
  assign idOp     = 6'(idOpFull);

  mips_ctrl_decode uDecode (
    .op   (idOp),
    .ctrl (idCtrl)
  );

  // Opcodes that decode to a bubble (unknown, J) carry no destination either.
  assign idDest = (idCtrl == CTRL_BUBBLE) ? '0
                : (idCtrl.RegDst ? bus.id_rd : bus.id_rt);

  assign branchTaken = (exCtrl.BranchEQ & bus.ex_zero) | (exCtrl.BranchNE & ~bus.ex_zero);
  assign loadUse     = exCtrl.MemRead && (exRt != '0) &&
                       ((exRt == bus.id_rs) || ((exRt == bus.id_rt) && usesRt(idOp)));
  assign stallInt     = loadUse & ~branchTaken;
  assign jumpInt      = (idOp == OP_J) & ~branchTaken & ~stallInt & ~reset;
  assign insertBubble = branchTaken | stallInt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exCtrl      <= CTRL_BUBBLE;
      exDest      <= '0;
      exRt        <= '0;
      memRead     <= 1'b0;
      memWrite    <= 1'b0;
      memMemtoReg <= 1'b0;
      memRegWrite <= 1'b0;
      memDest     <= '0;
      wbMemtoReg  <= 1'b0;
      wbRegWrite  <= 1'b0;
      wbDest      <= '0;
    end else begin
      exCtrl      <= insertBubble ? CTRL_BUBBLE : idCtrl;
      exDest      <= insertBubble ? '0 : idDest;
      exRt        <= insertBubble ? '0 : bus.id_rt;
      memRead     <= exCtrl.MemRead;
      memWrite    <= exCtrl.MemWrite;
      memMemtoReg <= exCtrl.MemtoReg;
      memRegWrite <= exCtrl.RegWrite;
      memDest     <= exDest;
      wbMemtoReg  <= memMemtoReg;
      wbRegWrite  <= memRegWrite;
      wbDest      <= memDest;
    end
  end

  assign bus.stall        = stallInt;
  assign bus.branch_taken = branchTaken;
  assign bus.jump         = jumpInt;
  assign bus.ifid_flush   = branchTaken | jumpInt;
  assign bus.ex_RegDst    = exCtrl.RegDst;
  assign bus.ex_ALUSrc    = exCtrl.ALUSrc;
  assign bus.ex_ALUOp     = ALUOP_W'(exCtrl.ALUOp);
  assign bus.ex_dest      = exDest;
  assign bus.mem_MemRead  = memRead;
  assign bus.mem_MemWrite = memWrite;
  assign bus.mem_dest     = memDest;
  assign bus.wb_MemtoReg  = wbMemtoReg;
  assign bus.wb_RegWrite  = wbRegWrite;
  assign bus.wb_dest      = wbDest;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt, flushCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stallInt && (stallCnt != '1))
        stallCnt <= stallCnt + CNT_W'(1);
      if ((branchTaken | jumpInt) && (flushCnt != '1))
        flushCnt <= flushCnt + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stallCnt;
  assign bus.flush_cnt = flushCnt;
`endif

endmodule
